controlador_suma_multibyte: RTL and testbench

//  Byte-serial sequencer that runs multi-byte add/subtract on one external 8-bit ripple

---
 rtl/controlador_suma_multibyte.sv | 129 ++++++++++++
 tb/tb_controlador_suma_multibyte.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/controlador_suma_multibyte.sv
// Byte-serial multi-byte add/subtract sequencer driving one shared external 8-bit adder.
// Processes one byte per clock, LSB first. The carry is chained through a register between bytes.
module controlador_suma_multibyte #(
    parameter int NUM_BYTES = 4
) (
    input  logic                     reloj,
    input  logic                     reinicio,
    input  logic                     inicio,
    input  logic                     resta,
    input  logic                     acarreo_entrada,
    input  logic [8*NUM_BYTES-1:0]   operandoA,
    input  logic [8*NUM_BYTES-1:0]   operandoB,
    output logic                     listo,
    output logic                     valido,
    output logic [8*NUM_BYTES-1:0]   resultado,
    output logic                     acarreo_salida,
    output logic                     desbordamiento,
    output logic [7:0]               sum_a,
    output logic [7:0]               sum_b,
    output logic                     sum_cin,
    input  logic [7:0]               sum_suma,
    input  logic                     sum_cout
);

    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        SUMANDO = 2'd1,
        HECHO   = 2'd2
    } estado_t;

    estado_t                       state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic                          carry_q, carry_d;
    logic [NUM_BYTES-1:0][7:0]     res_q, res_d;
    logic                          cout_q, cout_d;
    logic                          ovf_q, ovf_d;
    logic [NUM_BYTES-1:0][7:0]     a_q, a_d;
    logic [NUM_BYTES-1:0][7:0]     b_q, b_d;
    logic                          resta_q, resta_d;

    // Adder bus is forced to zero whenever no byte is in flight.
    always_comb begin
        sum_a   = '0;
        sum_b   = '0;
        sum_cin = 1'b0;
        if (state_q == SUMANDO) begin
            sum_a   = a_q[idx_q];
            sum_b   = b_q[idx_q] ^ {8{resta_q}};
            sum_cin = carry_q;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        a_d     = a_q;
        b_d     = b_q;
        resta_d = resta_q;
        case (state_q)
            REPOSO: begin
                if (inicio) begin
                    state_d = SUMANDO;
                    a_d     = operandoA;
                    b_d     = operandoB;
                    resta_d = resta;
                    // Subtraction is A + ~B + 1, so a zero borrow-in becomes carry-in 1.
                    carry_d = acarreo_entrada ^ resta;
                    idx_d   = '0;
                end
            end
            SUMANDO: begin
                res_d[idx_q] = sum_suma;
                carry_d      = sum_cout;
                idx_d        = idx_q + IDX_W'(1);
                if (idx_q == ULTIMO) begin
                    state_d = HECHO;
                    idx_d   = '0;
                    cout_d  = sum_cout;
                    ovf_d   = (sum_a[7] == sum_b[7]) & (sum_suma[7] != sum_a[7]);
                end
            end
            HECHO: begin
                state_d = REPOSO;
            end
            default: begin
                state_d = REPOSO;
            end
        endcase
    end

    always_ff @(posedge reloj) begin
        if (reinicio) begin
            state_q <= REPOSO;
            idx_q   <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand latches are only meaningful after acceptance and need no reset.
    always_ff @(posedge reloj) begin
        a_q     <= a_d;
        b_q     <= b_d;
        resta_q <= resta_d;
    end

    assign listo          = (state_q == REPOSO);
    assign valido         = (state_q == HECHO);
    assign resultado      = res_q;
    assign acarreo_salida = cout_q;
    assign desbordamiento = ovf_q;

endmodule

// File: tb/tb_controlador_suma_multibyte.sv
// Directed and random bench for controlador_suma_multibyte with NUM_BYTES=4.
// A behavioural 8-bit adder closes the loop on the sum_* bus.
module tb_controlador_suma_multibyte;

    logic        reloj = 1'b0;
    logic        reinicio, inicio, resta, acarreo_entrada;
    logic [31:0] operandoA, operandoB, resultado;
    logic        listo, valido, acarreo_salida, desbordamiento;
    logic [7:0]  sum_a, sum_b, sum_suma;
    logic        sum_cin, sum_cout;

    int n_checks = 0;
    int n_fail   = 0;

    controlador_suma_multibyte #(.NUM_BYTES(4)) dut (
        .reloj(reloj), .reinicio(reinicio), .inicio(inicio), .resta(resta),
        .acarreo_entrada(acarreo_entrada), .operandoA(operandoA), .operandoB(operandoB),
        .listo(listo), .valido(valido), .resultado(resultado),
        .acarreo_salida(acarreo_salida), .desbordamiento(desbordamiento),
        .sum_a(sum_a), .sum_b(sum_b), .sum_cin(sum_cin),
        .sum_suma(sum_suma), .sum_cout(sum_cout)
    );

    always #5 reloj = ~reloj;

    // External ripple adder model
    always_comb {sum_cout, sum_suma} = {1'b0, sum_a} + {1'b0, sum_b} + {8'd0, sum_cin};

    // Drives one operation from an idle cycle and waits (bounded) for valido.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic r, input logic c,
                          output logic [31:0] res, output logic co, output logic ov,
                          output int lat, output logic listo_at_v, output logic listo_after);
        operandoA = a; operandoB = b; resta = r; acarreo_entrada = c; inicio = 1'b1;
        @(posedge reloj); #1;
        inicio = 1'b0;
        lat = 0;
        while (valido !== 1'b1 && lat < 20) begin
            @(posedge reloj); #1;
            lat++;
        end
        res = resultado; co = acarreo_salida; ov = desbordamiento; listo_at_v = listo;
        @(posedge reloj); #1;
        listo_after = listo;
    endtask

    task automatic test_reset();
        reinicio = 1'b1; inicio = 1'b0; resta = 1'b0; acarreo_entrada = 1'b0;
        operandoA = '0; operandoB = '0;
        repeat (2) @(posedge reloj);
        #1;
        reinicio = 1'b0;
        n_checks++; if (listo !== 1'b1) begin n_fail++; $display("FAIL reset_listo got %b want 1", listo); end
        n_checks++; if (valido !== 1'b0) begin n_fail++; $display("FAIL reset_valido got %b want 0", valido); end
        n_checks++; if (resultado !== 32'h0) begin n_fail++; $display("FAIL reset_resultado got %h want 0", resultado); end
        n_checks++; if ({acarreo_salida, desbordamiento} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {acarreo_salida, desbordamiento}); end
        n_checks++; if ({sum_a, sum_b, sum_cin} !== 17'h0) begin n_fail++; $display("FAIL reset_sumbus got %h want 0", {sum_a, sum_b, sum_cin}); end
    endtask

    task automatic test_add();
        logic [31:0] res; logic co, ov, la, lb; int lat;
        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, res, co, ov, lat, la, lb);
        n_checks++; if (res !== 32'h00000100) begin n_fail++; $display("FAIL add_ff_1 got %h want 00000100", res); end
        n_checks++; if ({co, ov} !== 2'b00) begin n_fail++; $display("FAIL add_ff_1_flags got %b want 00", {co, ov}); end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL add_latency got %0d want 4", lat); end
        n_checks++; if (la !== 1'b0) begin n_fail++; $display("FAIL listo_during_valido got %b want 0", la); end
        n_checks++; if (lb !== 1'b1) begin n_fail++; $display("FAIL listo_after_valido got %b want 1", lb); end
        n_checks++; if (valido !== 1'b0) begin n_fail++; $display("FAIL valido_one_cycle got %b want 0", valido); end
        n_checks++; if (resultado !== 32'h00000100) begin n_fail++; $display("FAIL result_hold got %h want 00000100", resultado); end
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, res, co, ov, lat, la, lb);
        n_checks++; if ({res, co, ov} !== {32'h0, 2'b10}) begin n_fail++; $display("FAIL add_wrap got %h c%b v%b want 00000000 c1 v0", res, co, ov); end
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, res, co, ov, lat, la, lb);
        n_checks++; if ({res, co, ov} !== {32'h80000000, 2'b01}) begin n_fail++; $display("FAIL add_ovf got %h c%b v%b want 80000000 c0 v1", res, co, ov); end
        run_op(32'h12345678, 32'h11111111, 1'b0, 1'b1, res, co, ov, lat, la, lb);
        n_checks++; if ({res, co, ov} !== {32'h2345678A, 2'b00}) begin n_fail++; $display("FAIL add_cin got %h c%b v%b want 2345678a c0 v0", res, co, ov); end
    endtask

    task automatic test_sub();
        logic [31:0] res; logic co, ov, la, lb; int lat;
        run_op(32'h00000005, 32'h00000007, 1'b1, 1'b0, res, co, ov, lat, la, lb);
        n_checks++; if ({res, co, ov} !== {32'hFFFFFFFE, 2'b00}) begin n_fail++; $display("FAIL sub_neg got %h c%b v%b want fffffffe c0 v0", res, co, ov); end
        run_op(32'h80000000, 32'h00000001, 1'b1, 1'b0, res, co, ov, lat, la, lb);
        n_checks++; if ({res, co, ov} !== {32'h7FFFFFFF, 2'b11}) begin n_fail++; $display("FAIL sub_ovf got %h c%b v%b want 7fffffff c1 v1", res, co, ov); end
        run_op(32'h00000100, 32'h00000001, 1'b1, 1'b1, res, co, ov, lat, la, lb);
        n_checks++; if ({res, co, ov} !== {32'h000000FE, 2'b10}) begin n_fail++; $display("FAIL sub_borrow_in got %h c%b v%b want 000000fe c1 v0", res, co, ov); end
    endtask

    task automatic test_adder_bus();
        operandoA = 32'hA1B2C3D4; operandoB = 32'h0F0E0D0C; resta = 1'b1; acarreo_entrada = 1'b0; inicio = 1'b1;
        @(posedge reloj); #1;
        inicio = 1'b0;
        n_checks++; if ({sum_a, sum_b, sum_cin} !== {8'hD4, 8'hF3, 1'b1}) begin n_fail++; $display("FAIL bus_byte0 got %h %h %b want d4 f3 1", sum_a, sum_b, sum_cin); end
        @(posedge reloj); #1;
        n_checks++; if ({sum_a, sum_b} !== {8'hC3, 8'hF2}) begin n_fail++; $display("FAIL bus_byte1 got %h %h want c3 f2", sum_a, sum_b); end
        repeat (3) @(posedge reloj);
        #1;
        n_checks++; if ({valido, sum_a, sum_b, sum_cin} !== {1'b1, 17'h0}) begin n_fail++; $display("FAIL bus_idle_hecho got v%b %h %h %b want v1 0 0 0", valido, sum_a, sum_b, sum_cin); end
        n_checks++; if (resultado !== 32'h92A4B6C8) begin n_fail++; $display("FAIL bus_result got %h want 92a4b6c8", resultado); end
        @(posedge reloj); #1;
    endtask

    task automatic test_inicio_held();
        int nval = 0;
        operandoA = 32'h1; operandoB = 32'h2; resta = 1'b0; acarreo_entrada = 1'b0; inicio = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge reloj); #1;
            if (k == 1) begin operandoA = 32'h100; operandoB = 32'h200; end
            if (valido === 1'b1) begin
                nval++;
                n_checks++;
                if (k == 5) begin
                    if (resultado !== 32'h3) begin n_fail++; $display("FAIL held_op1 got %h want 00000003", resultado); end
                end else if (k == 11) begin
                    if (resultado !== 32'h300) begin n_fail++; $display("FAIL held_op2 got %h want 00000300", resultado); end
                end else begin
                    n_fail++; $display("FAIL held_valido_cycle got %0d want 5 or 11", k);
                end
            end
        end
        inicio = 1'b0;
        n_checks++; if (nval !== 2) begin n_fail++; $display("FAIL held_valido_count got %0d want 2", nval); end
        repeat (8) @(posedge reloj);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] res; logic co, ov, la, lb; int lat; int nval = 0;
        operandoA = 32'h11223344; operandoB = 32'h01010101; resta = 1'b0; acarreo_entrada = 1'b0; inicio = 1'b1;
        @(posedge reloj); #1;
        inicio = 1'b0;
        @(posedge reloj); #1;
        reinicio = 1'b1;
        @(posedge reloj); #1;
        reinicio = 1'b0;
        n_checks++; if ({listo, valido} !== 2'b10) begin n_fail++; $display("FAIL midreset_ctrl got l%b v%b want l1 v0", listo, valido); end
        n_checks++; if (resultado !== 32'h0) begin n_fail++; $display("FAIL midreset_resultado got %h want 0", resultado); end
        for (int k = 0; k < 6; k++) begin
            @(posedge reloj); #1;
            if (valido === 1'b1) nval++;
        end
        n_checks++; if (nval !== 0) begin n_fail++; $display("FAIL midreset_no_valido got %0d want 0", nval); end
        run_op(32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, res, co, ov, lat, la, lb);
        n_checks++; if ({res, co, ov, lat} !== {32'h0001FFFE, 2'b00, 32'd4}) begin n_fail++; $display("FAIL midreset_next got %h c%b v%b lat%0d want 0001fffe c0 v0 lat4", res, co, ov, lat); end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, eres; logic r, c, co, ov, la, lb, eco, eov; logic [32:0] full; int lat;
        for (int n = 0; n < 10000; n++) begin
            a = $urandom; b = $urandom; r = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
            if (n % 16 == 0) a = 32'h80000000;
            if (n % 16 == 1) b = 32'h7FFFFFFF;
            n_checks++;
            if ({listo, sum_a, sum_b, sum_cin} !== {1'b1, 17'h0}) begin n_fail++; $display("FAIL rnd_idle_bus op%0d got l%b %h %h %b want l1 0 0 0", n, listo, sum_a, sum_b, sum_cin); end
            if (r) begin
                full = {1'b0, a} - {1'b0, b} - {32'd0, c};
                eres = full[31:0]; eco = ~full[32];
                eov = (a[31] != b[31]) && (eres[31] != a[31]);
            end else begin
                full = {1'b0, a} + {1'b0, b} + {32'd0, c};
                eres = full[31:0]; eco = full[32];
                eov = (a[31] == b[31]) && (eres[31] != a[31]);
            end
            run_op(a, b, r, c, res, co, ov, lat, la, lb);
            n_checks++;
            if ({res, co, ov, lat} !== {eres, eco, eov, 32'd4}) begin
                n_fail++;
                $display("FAIL rnd_op%0d a=%h b=%h r%b c%b got %h c%b v%b lat%0d want %h c%b v%b lat4", n, a, b, r, c, res, co, ov, lat, eres, eco, eov);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_adder_bus();
        test_inicio_held();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
